// File: rtl/sram_arbiter_if.sv
// Bundle between the CPU/loader requesters, the arbiter and the SRAM pins.
// The slave modport is the arbiter's view; master is the requester/board view.
interface sram_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;

   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic [DATA_W-1:0] ldr_rdata;
   logic              ldr_done;

   logic              arb_owner;
   logic              arb_busy;

   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dq_out;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_in;
   logic              Mem_CE;
   logic              Mem_UB;
   logic              Mem_LB;
   logic              Mem_OE;
   logic              Mem_WE;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_rdata, ldr_done,
      output arb_owner, arb_busy,
      output sram_addr, sram_dq_out, sram_dq_oe,
      input  sram_dq_in,
      output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_rdata, ldr_done,
      input  arb_owner, arb_busy,
      input  sram_addr, sram_dq_out, sram_dq_oe,
      output sram_dq_in,
      input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for one asynchronous 16-bit SRAM (CPU vs loader).
// Sequences OE/WE timing and returns a one-cycle done to the owner.
module sram_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 16,
   parameter int RD_WAIT  = 2,
   parameter int WR_PULSE = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   sram_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SU,
      WR,
      WR_HD,
      DONE
   } state_e;

   localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
   localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] crd_q, crd_d;
   logic [DATA_W-1:0] lrd_q, lrd_d;

   logic ce_q, ce_d;
   logic oe_q, oe_d;
   logic we_q, we_d;
   logic dqoe_q, dqoe_d;
   logic cdone_q, cdone_d;
   logic ldone_q, ldone_d;

   logic any_req;
   logic gnt_ldr;
   logic gnt_we;

   // On a tie the port that did not own the previous access wins.
   assign any_req = bus.cpu_req | bus.ldr_req;
   assign gnt_ldr = bus.ldr_req & (~bus.cpu_req | ~last_q);
   assign gnt_we  = gnt_ldr ? bus.ldr_we : bus.cpu_we;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      crd_d   = crd_q;
      lrd_d   = lrd_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d = gnt_ldr;
               last_d  = gnt_ldr;
               cnt_d   = 4'd0;
               addr_d  = gnt_ldr ? bus.ldr_addr : bus.cpu_addr;
               wdata_d = gnt_ldr ? bus.ldr_wdata : bus.cpu_wdata;
               state_d = gnt_we ? WR_SU : RD;
            end
         end
         RD: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == RD_LAST) begin
               if (owner_q) lrd_d = bus.sram_dq_in;
               else         crd_d = bus.sram_dq_in;
               state_d = DONE;
            end
         end
         WR_SU: begin
            cnt_d   = 4'd0;
            state_d = WR;
         end
         WR: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WR_LAST) state_d = WR_HD;
         end
         WR_HD: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin controls come straight from flops so the SRAM never sees glitches.
   always_comb begin
      ce_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      dqoe_d  = 1'b0;
      cdone_d = 1'b0;
      ldone_d = 1'b0;
      unique case (state_d)
         IDLE: ;
         RD: begin
            ce_d = 1'b0;
            oe_d = 1'b0;
         end
         WR_SU, WR_HD: begin
            ce_d   = 1'b0;
            dqoe_d = 1'b1;
         end
         WR: begin
            ce_d   = 1'b0;
            dqoe_d = 1'b1;
            we_d   = 1'b0;
         end
         DONE: begin
            ce_d    = 1'b0;
            cdone_d = ~owner_d;
            ldone_d = owner_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         crd_q   <= '0;
         lrd_q   <= '0;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         we_q    <= 1'b1;
         dqoe_q  <= 1'b0;
         cdone_q <= 1'b0;
         ldone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         crd_q   <= crd_d;
         lrd_q   <= lrd_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         dqoe_q  <= dqoe_d;
         cdone_q <= cdone_d;
         ldone_q <= ldone_d;
      end
   end

   assign bus.cpu_rdata   = crd_q;
   assign bus.ldr_rdata   = lrd_q;
   assign bus.cpu_done    = cdone_q;
   assign bus.ldr_done    = ldone_q;
   assign bus.arb_owner   = owner_q;
   assign bus.arb_busy    = (state_q != IDLE);
   assign bus.sram_addr   = addr_q;
   assign bus.sram_dq_out = wdata_q;
   assign bus.sram_dq_oe  = dqoe_q;
   assign bus.Mem_CE      = ce_q;
   assign bus.Mem_UB      = ce_q;
   assign bus.Mem_LB      = ce_q;
   assign bus.Mem_OE      = oe_q;
   assign bus.Mem_WE      = we_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Random two-port traffic against an SRAM model; a scoreboard monitor
// checks grants, pin timing, done pulses and read data.
`timescale 1ns/1ps
module tb_sram_arbiter;
   localparam int AW = 20;
   localparam int DW = 16;
   localparam int RDW = 2;
   localparam int WRP = 2;
   localparam int RD_LAT = RDW + 1;
   localparam int WR_LAT = WRP + 3;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } txn_t;

   logic Clk = 1'b0;
   logic Reset;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_PULSE(WRP)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus.slave)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   txn_t cq[$];
   txn_t lq[$];
   logic [DW-1:0] ref_mem [2][8];
   logic [DW-1:0] sram [logic [AW-1:0]];
   bit mon_en = 1'b0;

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      logic [AW-1:0] t;
      t = a * 20'h09E37;
      return t[DW-1:0] ^ 16'hC35A;
   endfunction

   function automatic logic [AW-1:0] base(input bit p);
      return p ? 20'h80040 : 20'h00120;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit p, input bit req, input txn_t x);
      if (!p) begin
         bus.cpu_req = req; bus.cpu_we = x.we;
         bus.cpu_addr = x.addr; bus.cpu_wdata = x.wdata;
      end else begin
         bus.ldr_req = req; bus.ldr_we = x.we;
         bus.ldr_addr = x.addr; bus.ldr_wdata = x.wdata;
      end
   endtask

   // Asynchronous SRAM behaviour: write while WE low, drive data while OE low
   always @(negedge Clk) begin
      if (!bus.Mem_CE && !bus.Mem_WE) sram[bus.sram_addr] = bus.sram_dq_out;
      if (!bus.Mem_CE && !bus.Mem_OE)
         bus.sram_dq_in = sram.exists(bus.sram_addr) ?
                          sram[bus.sram_addr] : init_word(bus.sram_addr);
      else
         bus.sram_dq_in = 16'h5A5A;
   end

   // Scoreboard monitor
   bit   prev_busy, prev_c, prev_l, last_own, cur_own, cur_valid, eo;
   int   bcnt, tlen;
   txn_t cur;
   logic [DW-1:0] exp_crd, exp_lrd;
   bit   oe_n, we_n, dqoe;

   always @(negedge Clk) begin
      if (!mon_en) begin
         prev_busy = 0; prev_c = 0; prev_l = 0; last_own = 1;
         bcnt = 0; tlen = 0; cur_valid = 0; exp_crd = '0; exp_lrd = '0;
      end else begin
         chk("oe_we_excl", 32'(bus.Mem_OE | bus.Mem_WE), 1);
         chk("ce_busy", 32'(bus.Mem_CE), 32'(!bus.arb_busy));
         chk("ub_lb", 32'({bus.Mem_UB, bus.Mem_LB}), 32'({2{bus.Mem_CE}}));
         if (bus.arb_busy && !prev_busy) begin
            eo = (prev_c && prev_l) ? !last_own : prev_l;
            chk("grant_req_seen", 32'(prev_c | prev_l), 1);
            chk("grant_owner", 32'(bus.arb_owner), 32'(eo));
            last_own = bus.arb_owner;
            cur_own = bus.arb_owner;
            cur_valid = cur_own ? (lq.size() > 0) : (cq.size() > 0);
            chk("grant_has_txn", 32'(cur_valid), 1);
            if (cur_valid) cur = cur_own ? lq[0] : cq[0];
            tlen = cur.we ? WR_LAT : RD_LAT;
            bcnt = 1;
         end else if (bus.arb_busy) begin
            bcnt++;
         end
         if (!bus.arb_busy && prev_busy && cur_valid)
            chk("txn_len", bcnt, tlen);
         if (bus.arb_busy && cur_valid) begin
            oe_n = cur.we || bcnt > RDW;
            we_n = !cur.we || bcnt < 2 || bcnt > WRP + 1;
            dqoe = cur.we && bcnt <= WRP + 2;
            chk("owner_stable", 32'(bus.arb_owner), 32'(cur_own));
            chk("busy_overrun", 32'(bcnt <= tlen), 1);
            chk("sram_addr", 32'(bus.sram_addr), 32'(cur.addr));
            if (cur.we) chk("dq_out", 32'(bus.sram_dq_out), 32'(cur.wdata));
            chk("mem_oe", 32'(bus.Mem_OE), 32'(oe_n));
            chk("mem_we", 32'(bus.Mem_WE), 32'(we_n));
            chk("dq_oe", 32'(bus.sram_dq_oe), 32'(dqoe));
            chk("cpu_done", 32'(bus.cpu_done), 32'(bcnt == tlen && !cur_own));
            chk("ldr_done", 32'(bus.ldr_done), 32'(bcnt == tlen && cur_own));
            if (bcnt == tlen) begin
               if (!cur.we) begin
                  if (cur_own) exp_lrd = cur.rdata;
                  else         exp_crd = cur.rdata;
               end
               if (cur_own) void'(lq.pop_front());
               else         void'(cq.pop_front());
            end
         end
         if (!bus.arb_busy)
            chk("idle_pins", 32'({bus.cpu_done, bus.ldr_done, bus.sram_dq_oe,
                                  bus.Mem_OE, bus.Mem_WE}), 32'(5'b00011));
         chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_crd));
         chk("ldr_rdata", 32'(bus.ldr_rdata), 32'(exp_lrd));
         prev_busy = bus.arb_busy;
         prev_c = bus.cpu_req;
         prev_l = bus.ldr_req;
      end
   end

   // One requester: issue, wait for done, optionally keep req high for the next
   task automatic run_port(input bit p, input int n);
      txn_t x, g;
      int idx, gap;
      bit got, granted, hold;
      for (int t = 0; t < n; t++) begin
         idx = $urandom_range(0, 7);
         x.we = 1'($urandom_range(0, 1));
         x.addr = base(p) + AW'(idx);
         x.wdata = DW'($urandom);
         if (x.we) begin
            ref_mem[p][idx] = x.wdata;
            x.rdata = '0;
         end else begin
            x.rdata = ref_mem[p][idx];
         end
         if (p) lq.push_back(x);
         else   cq.push_back(x);
         drive(p, 1'b1, x);
         got = 0;
         granted = 0;
         for (int c = 0; c < 200 && !got; c++) begin
            @(negedge Clk);
            if (bus.arb_busy && bus.arb_owner == p) granted = 1;
            got = p ? bus.ldr_done : bus.cpu_done;
            if (!got) begin
               @(posedge Clk); #1;
               if (granted && $urandom_range(0, 1) == 1) begin
                  g.we = 1'($urandom_range(0, 1));
                  g.addr = AW'($urandom);
                  g.wdata = DW'($urandom);
                  g.rdata = '0;
                  drive(p, 1'b1, g);
               end
            end
         end
         chk(p ? "ldr_timeout" : "cpu_timeout", 32'(got), 1);
         @(posedge Clk); #1;
         hold = ($urandom_range(0, 3) == 0) && (t < n - 1);
         if (!hold) begin
            drive(p, 1'b0, x);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
               @(posedge Clk); #1;
            end
         end
      end
      drive(p, 1'b0, x);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t z;
      bit got;
      z = '0;
      Reset = 1'b1;
      drive(0, 1'b0, z);
      drive(1, 1'b0, z);
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 8; i++)
            ref_mem[p][i] = init_word(base(1'(p)) + AW'(i));
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_rdata", 32'({bus.cpu_rdata, bus.ldr_rdata}), 0);
      chk("rst_addr", 32'(bus.sram_addr), 0);
      chk("rst_dq_out", 32'(bus.sram_dq_out), 0);
      chk("rst_ctl", 32'({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB,
                          bus.Mem_OE, bus.Mem_WE}), 32'(5'h1F));
      chk("rst_busy", 32'({bus.arb_busy, bus.sram_dq_oe,
                           bus.cpu_done, bus.ldr_done}), 0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      mon_en = 1'b1;

      fork
         run_port(0, 60);
         run_port(1, 60);
      join

      // Reset in the middle of a write pulse
      repeat (3) @(posedge Clk); #1;
      mon_en = 1'b0;
      z.we = 1'b1;
      z.addr = base(0) + 20'd7;
      z.wdata = ref_mem[0][7];
      z.rdata = '0;
      drive(0, 1'b1, z);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge Clk);
         got = bus.arb_busy;
      end
      chk("rst_wr_grant", 32'(got), 1);
      chk("rst_wr_su", 32'({bus.Mem_WE, bus.sram_dq_oe}), 32'(2'b11));
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(negedge Clk);
      chk("rst_in_wr", 32'({bus.Mem_WE, bus.sram_dq_oe}), 32'(2'b01));
      @(negedge Clk);
      chk("rst_abort", 32'({bus.Mem_WE, bus.Mem_CE, bus.Mem_OE, bus.sram_dq_oe,
                            bus.arb_busy, bus.cpu_done, bus.ldr_done}),
          32'(7'b1110000));
      @(posedge Clk); #1;
      Reset = 1'b0;
      drive(0, 1'b0, z);
      repeat (WR_LAT + 2) begin
         @(negedge Clk);
         chk("rst_no_done", 32'({bus.cpu_done, bus.ldr_done, bus.arb_busy}), 0);
      end
      @(posedge Clk); #1;
      mon_en = 1'b1;

      fork
         run_port(0, 12);
         run_port(1, 12);
      join

      repeat (3) @(negedge Clk);
      chk("sb_empty", 32'(cq.size() + lq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates one asynchronous 16-bit SRAM between two requesters: the CPU control path (cpu_*) and the program loader/debug port (ldr_*).
- Sequences each access with the SRAM's multi-cycle OE/WE timing and returns a one-cycle done pulse to the owning requester.
- Sits between the control unit / memory-contents loader and the board SRAM pins, and replaces fixed per-state Mem_OE/Mem_WE driving.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_WAIT, 2, cycles Mem_OE is held low per read; legal range 1..15.
- WR_PULSE, 2, cycles Mem_WE is held low per write; legal range 1..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  last data read for the CPU (registered).
- cpu_done  out  1  one-cycle completion pulse.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_done: same as the cpu_* ports, for the loader.
- arb_owner  out  1  0 = CPU, 1 = loader; valid when arb_busy = 1.
- arb_busy  out  1  1 in every state except IDLE.
- sram_addr  out  ADDR_W  SRAM address (registered).
- sram_dq_out  out  DATA_W  write data driven to the SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out.
- sram_dq_in  in  DATA_W  read data from the SRAM.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM controls, active low.

Behaviour:
Reset
- Reset is synchronous and active-high.
- On the next rising edge of Clk with Reset = 1, regardless of current state (including mid-write):
  - state = IDLE; last_owner = 1 (loader), so the CPU wins the first tie.
  - cpu_rdata = ldr_rdata = 0; sram_addr = 0; sram_dq_out = 0.
  - All done pulses = 0; sram_dq_oe = 0; arb_busy = 0.
  - Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE = 1.

State machine
- States: IDLE, RD, WR_SU, WR, WR_HD, DONE. A 4-bit counter cnt times RD and WR.
- IDLE:
  - Sample requests. With a single request, grant it. With both requests, grant the port that is not last_owner.
  - At the grant edge:
    - Latch owner, we, addr and wdata into sram_addr and sram_dq_out.
    - Set last_owner = owner; cnt = 0.
    - Go to RD if we = 0, else go to WR_SU.
- RD: Mem_OE = 0. cnt increments each cycle. When cnt = RD_WAIT-1, capture sram_dq_in into the owner's rdata and go to DONE.
- WR_SU: one cycle with sram_dq_oe = 1 and Mem_WE = 1. Set cnt = 0, then go to WR.
- WR: Mem_WE = 0 and sram_dq_oe = 1. When cnt = WR_PULSE-1, go to WR_HD.
- WR_HD: one cycle with Mem_WE = 1 and sram_dq_oe = 1, then go to DONE.
- DONE:
  - Assert the owner's done for exactly one cycle; the other done stays 0. Then go to IDLE.
  - The owner's rdata is valid from the DONE cycle onward and holds until that port's next read completes.

Outputs by state
- Mem_CE = Mem_UB = Mem_LB = 0 in RD, WR_SU, WR, WR_HD and DONE; 1 in IDLE. Only word accesses are supported.
- Mem_OE and Mem_WE are never low in the same cycle.

Latency, with the request seen in IDLE at cycle 0
- Read: done at cycle RD_WAIT+1.
- Write: done at cycle WR_PULSE+3.

Requester protocol
- A requester deasserts req in the cycle after it sees done.
- A req still high in the IDLE cycle that follows DONE is treated as a new transaction.
- A request arriving while arb_busy = 1 waits, with no loss, and is granted in the next IDLE.
- Changes to addr, we or wdata after the grant edge have no effect on the access in progress.
- Minimum gap between back-to-back transactions: 1 IDLE cycle.

Fairness
- Under continuous requests from both ports, grants strictly alternate.
- Neither port ever waits more than one foreign transaction.

Test Plan:
- CPU read, RD_WAIT=2, cpu_addr=20'h00123, sram_dq_in=16'hBEEF -> sram_addr=20'h00123 from cycle 1; Mem_OE=0 in cycles 1-2; cpu_done=1 only in cycle 3; cpu_rdata=16'hBEEF; ldr_done stays 0.
- Loader write, WR_PULSE=2, ldr_addr=20'h00040, ldr_wdata=16'h3042 -> sram_dq_oe=1 in cycles 1-4; Mem_WE=0 only in cycles 2-3; ldr_done in cycle 5; Mem_OE=1 throughout.
- Both ports request reads at once after reset -> CPU is served first; loader is granted in the IDLE after CPU DONE; with both held continuously, arb_owner alternates 0,1,0,1.
- Loader requests at cycle 2 of a CPU read -> loader waits; the loader access starts on the edge after the CPU IDLE cycle; the CPU result is unaffected.
- Reset asserted during WR (cycle 2 of a write) -> on the next edge Mem_WE=1, Mem_CE=1, sram_dq_oe=0, arb_busy=0; no done pulse; the next request is granted normally.
- CPU holds cpu_req high through cpu_done -> a second transaction to the same address starts from the following IDLE cycle; exactly one done pulse per transaction.
